// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default byte width used by the UART data path.
package uart_pkg;

   localparam int DATA_BITS_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arbState_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search. The search begins one past the
// previous grant and wraps, so the previous winner has the lowest priority.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [N_REQ-1:0] grant_onehot,
   output logic [IW-1:0]    grant_idx,
   output logic             any_req
);

   // Walk the requesters in rotating order and keep the first one found.
   always_comb begin
      logic found;
      int   idxWide;
      logic [IW-1:0] idx;
      grant_onehot = '0;
      grant_idx    = '0;
      found        = 1'b0;
      idxWide      = 0;
      idx          = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idxWide = (int'(last_grant) + k) % N_REQ;
         idx     = IW'(idxWide);
         if (!found && req[idx]) begin
            found             = 1'b1;
            grant_onehot[idx] = 1'b1;
            grant_idx         = idx;
         end
      end
   end

   // Any set request means a winner exists this cycle.
   always_comb begin
      any_req = |req;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte requesters. A winner is
// accepted in IDLE, a one-cycle start strobe is issued, and the arbiter then
// waits for the transmitter to go busy (bounded by START_TIMEOUT) and to
// report the end of the frame before accepting again.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int DATA_BITS     = DATA_BITS_DEFAULT,
   parameter int START_TIMEOUT = 64
) (
   input  logic                         sysclk_in,
   input  logic                         nrst_in,
   input  logic [N_REQ-1:0]             req_valid_in,
   input  logic [N_REQ*DATA_BITS-1:0]   req_data_in,
   output logic [N_REQ-1:0]             req_ready_out,
   output logic [DATA_BITS-1:0]         tx_data_out,
   output logic                         tx_start_out,
   input  logic                         tx_busy_in,
   input  logic                         tx_done_in,
   output logic [$clog2(N_REQ)-1:0]     grant_idx_out,
   output logic                         busy_out,
   output logic                         timeout_err_out
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(START_TIMEOUT + 1);

   arbState_e          state_q;
   logic [IW-1:0]      lastGrant_q;
   logic [IW-1:0]      grantIdx_q;
   logic [DATA_BITS-1:0] txData_q;
   logic               txStart_q;
   logic               timeoutErr_q;
   logic [CW-1:0]      timeoutCnt_q;

   logic [N_REQ-1:0]   grantOnehot;
   logic [IW-1:0]      grantIdx;
   logic               anyReq;
   logic [DATA_BITS-1:0] winnerData;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr (
      .req          (req_valid_in),
      .last_grant   (lastGrant_q),
      .grant_onehot (grantOnehot),
      .grant_idx    (grantIdx),
      .any_req      (anyReq)
   );

   // Select the byte belonging to the current round-robin winner.
   always_comb begin
      winnerData = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grantOnehot[i]) begin
            winnerData = req_data_in[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   // Arbitration FSM; the counter counts cycles since the start strobe, so
   // it is zero during START and reaches START_TIMEOUT-1 on the last
   // WAIT_BUSY cycle, which puts the error pulse START_TIMEOUT cycles after
   // the strobe.
   always_ff @(posedge sysclk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state_q      <= IDLE;
         lastGrant_q  <= IW'(N_REQ - 1);
         grantIdx_q   <= '0;
         txData_q     <= '0;
         txStart_q    <= 1'b0;
         timeoutErr_q <= 1'b0;
         timeoutCnt_q <= '0;
      end else begin
         txStart_q    <= 1'b0;
         timeoutErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (anyReq) begin
                  txData_q     <= winnerData;
                  grantIdx_q   <= grantIdx;
                  lastGrant_q  <= grantIdx;
                  timeoutCnt_q <= '0;
                  txStart_q    <= 1'b1;
                  state_q      <= START;
               end
            end
            START: begin
               timeoutCnt_q <= timeoutCnt_q + CW'(1);
               state_q      <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy_in) begin
                  state_q <= WAIT_DONE;
               end else if (timeoutCnt_q >= CW'(START_TIMEOUT - 1)) begin
                  timeoutErr_q <= 1'b1;
                  state_q      <= IDLE;
               end else begin
                  timeoutCnt_q <= timeoutCnt_q + CW'(1);
               end
            end
            WAIT_DONE: begin
               if (tx_done_in) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Ready is only offered while idle and never while reset is held, so a
   // reset silences the accept strobe immediately.
   always_comb begin
      req_ready_out = '0;
      if ((state_q == IDLE) && nrst_in) begin
         req_ready_out = grantOnehot;
      end
   end

   // Drive the remaining outputs straight from their registers.
   always_comb begin
      tx_data_out     = txData_q;
      tx_start_out    = txStart_q;
      grant_idx_out   = grantIdx_q;
      timeout_err_out = timeoutErr_q;
      busy_out        = (state_q != IDLE);
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter. A behavioural transmitter plans busy
// and done timing per frame, and a cycle-level reference model predicts
// accepts, strobes, timeouts and held outputs from the arbitration rules.
module tb_uart_tx_arbiter;

   localparam int N_REQ         = 4;
   localparam int DATA_BITS     = 8;
   localparam int START_TIMEOUT = 64;
   localparam int IW            = $clog2(N_REQ);
   localparam int N_CYCLES      = 1600;

   logic                       sysclk_in = 1'b0;
   logic                       nrst_in;
   logic [N_REQ-1:0]           req_valid_in;
   logic [N_REQ*DATA_BITS-1:0] req_data_in;
   logic [N_REQ-1:0]           req_ready_out;
   logic [DATA_BITS-1:0]       tx_data_out;
   logic                       tx_start_out;
   logic                       tx_busy_in;
   logic                       tx_done_in;
   logic [IW-1:0]              grant_idx_out;
   logic                       busy_out;
   logic                       timeout_err_out;

   int testsRun    = 0;
   int testsFailed = 0;
   int cyc         = 0;

   // Reference model state, expressed in absolute cycle numbers.
   int expLast;
   int expData;
   int expIdx;
   bit frameActive;
   bit busySeen;
   int busyCycle;
   int startCycle;
   int timeoutCycle;
   bit didReset;

   // Behavioural transmitter plan for the current frame.
   int planBusyStart;
   int planDone;
   int planSpurious;
   bit planTimeout;

   always #5 sysclk_in = ~sysclk_in;

   uart_tx_arbiter #(
      .N_REQ         (N_REQ),
      .DATA_BITS     (DATA_BITS),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .sysclk_in       (sysclk_in),
      .nrst_in         (nrst_in),
      .req_valid_in    (req_valid_in),
      .req_data_in     (req_data_in),
      .req_ready_out   (req_ready_out),
      .tx_data_out     (tx_data_out),
      .tx_start_out    (tx_start_out),
      .tx_busy_in      (tx_busy_in),
      .tx_done_in      (tx_done_in),
      .grant_idx_out   (grant_idx_out),
      .busy_out        (busy_out),
      .timeout_err_out (timeout_err_out)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                  tag, cyc, actual, expected);
      end
   endtask

   // Rotating priority search starting one past the last accepted requester.
   function automatic int rrWinner();
      for (int k = 1; k <= N_REQ; k++) begin
         if (req_valid_in[(expLast + k) % N_REQ]) return (expLast + k) % N_REQ;
      end
      return -1;
   endfunction

   task automatic resetModel();
      expLast       = N_REQ - 1;
      expData       = 0;
      expIdx        = 0;
      frameActive   = 1'b0;
      busySeen      = 1'b0;
      busyCycle     = -1000;
      startCycle    = -1000;
      timeoutCycle  = -1000;
      planBusyStart = -100;
      planDone      = -100;
      planSpurious  = -100;
      planTimeout   = 1'b0;
   endtask

   // Drive requesters and the transmitter model for the current cycle.
   task automatic applyStimulus();
      if (cyc >= 200 && cyc < 320) begin
         req_valid_in = '1;
      end else if ($urandom_range(0, 3) == 0) begin
         req_valid_in = '0;
      end else begin
         req_valid_in = N_REQ'($urandom);
      end
      for (int i = 0; i < N_REQ; i++) begin
         req_data_in[i*DATA_BITS +: DATA_BITS] = DATA_BITS'($urandom);
      end
      tx_busy_in = !planTimeout && (cyc >= planBusyStart) && (cyc <= planDone);
      tx_done_in = (!planTimeout && cyc == planDone) || (cyc == planSpurious);
   endtask

   // Record an accept and plan how the transmitter will answer the frame.
   task automatic modelAccept(input int w);
      expLast     = w;
      expIdx      = w;
      expData     = int'(req_data_in[w*DATA_BITS +: DATA_BITS]);
      frameActive = 1'b1;
      busySeen    = 1'b0;
      startCycle  = cyc + 1;
      planTimeout = ($urandom_range(0, 5) == 0);
      if (planTimeout) begin
         planBusyStart = -100;
         planDone      = -100;
         planSpurious  = ($urandom_range(0, 1) == 0) ?
                         startCycle + $urandom_range(1, 60) : -100;
      end else begin
         planBusyStart = startCycle + $urandom_range(1, 4);
         planDone      = planBusyStart + $urandom_range(1, 6);
         planSpurious  = (planBusyStart > startCycle + 1 &&
                          $urandom_range(0, 1) == 0) ? startCycle + 1 : -100;
      end
   endtask

   // Advance the reference model across the coming rising edge.
   task automatic modelStep();
      int w;
      if (!frameActive) begin
         w = rrWinner();
         if (w >= 0) modelAccept(w);
      end else if (!busySeen) begin
         if (cyc > startCycle && tx_busy_in) begin
            busySeen  = 1'b1;
            busyCycle = cyc;
         end else if (cyc == startCycle + START_TIMEOUT - 1) begin
            frameActive  = 1'b0;
            timeoutCycle = cyc + 1;
         end
      end else if (cyc > busyCycle && tx_done_in) begin
         frameActive = 1'b0;
      end
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic checkCycle();
      logic [N_REQ-1:0] expReady;
      int w;
      expReady = '0;
      w = rrWinner();
      if (!frameActive && w >= 0) expReady[w] = 1'b1;
      checkOutput("ready",    32'(req_ready_out),   32'(expReady));
      checkOutput("start",    32'(tx_start_out),    32'(cyc == startCycle));
      checkOutput("timeout",  32'(timeout_err_out), 32'(cyc == timeoutCycle));
      checkOutput("busy",     32'(busy_out),        32'(frameActive));
      checkOutput("tx_data",  32'(tx_data_out),     32'(expData));
      checkOutput("grant_ix", 32'(grant_idx_out),   32'(expIdx));
   endtask

   // Reset-value checks shared by power-up and mid-frame reset.
   task automatic checkResetOutputs(input string phase);
      checkOutput({phase, "_ready"},   32'(req_ready_out),   32'd0);
      checkOutput({phase, "_start"},   32'(tx_start_out),    32'd0);
      checkOutput({phase, "_timeout"}, 32'(timeout_err_out), 32'd0);
      checkOutput({phase, "_busy"},    32'(busy_out),        32'd0);
      checkOutput({phase, "_data"},    32'(tx_data_out),     32'd0);
      checkOutput({phase, "_grant"},   32'(grant_idx_out),   32'd0);
   endtask

   initial begin
      resetModel();
      didReset     = 1'b0;
      nrst_in      = 1'b0;
      req_valid_in = '1;
      req_data_in  = '0;
      tx_busy_in   = 1'b0;
      tx_done_in   = 1'b0;
      #1;
      checkResetOutputs("por");
      req_valid_in = '0;
      repeat (2) @(negedge sysclk_in);
      nrst_in = 1'b1;

      for (int c = 1; c <= N_CYCLES; c++) begin
         @(negedge sysclk_in);
         cyc = c;
         applyStimulus();
         if (!didReset && cyc >= 700 && frameActive && busySeen && cyc > busyCycle) begin
            nrst_in      = 1'b0;
            req_valid_in = '1;
            tx_busy_in   = 1'b0;
            tx_done_in   = 1'b0;
            #1;
            checkResetOutputs("midrst");
            nrst_in  = 1'b1;
            didReset = 1'b1;
            resetModel();
         end
         #1;
         checkCycle();
         modelStep();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
